// File: rtl/ahb_boot_master.sv
// Command-driven AHB-Lite master for the code-memory M0 port.
// Each command is a 1..16 word burst that goes out as single NONSEQ
// transfers. Write data is pulled from a stream one word per beat.
// Read data is pushed to a stream one word per beat. Every command ends
// with a DONE pulse that carries a STATUS code.
module ahb_boot_master #(
    parameter int TIMEOUT_CYC = 256,
    parameter int ADDR_INC    = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_ADDR,
    input  logic        CMD_WRITE,
    input  logic [3:0]  CMD_LEN,
    input  logic        WD_VALID,
    output logic        WD_READY,
    input  logic [31:0] WD_DATA,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic [31:0] RD_DATA,
    output logic        RD_LAST,
    output logic        DONE,
    output logic [1:0]  STATUS,
    output logic [31:0] HADDR_M0,
    output logic [1:0]  HTRANS_M0,
    output logic        HWRITE_M0,
    output logic [2:0]  HSIZE_M0,
    output logic [2:0]  HBURST_M0,
    output logic [3:0]  HPROT_M0,
    output logic        HMASTLOCK_M0,
    output logic [31:0] HWDATA_M0,
    input  logic [31:0] HRDATA_M0,
    input  logic        HREADY_M0,
    input  logic [1:0]  HRESP_M0
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WFETCH, S_ADDR, S_DATA, S_RHOLD, S_FINISH
    } state_t;

    state_t         state, state_nx;
    logic [31:0]    addr_q, wdata_q, rdata_q;
    logic           write_q, rlast_q;
    logic [4:0]     beats_q;        // beats still to run, including the current one
    logic [1:0]     status_q, status_nx;
    logic [TW-1:0]  to_cnt;

    logic ld_cmd, ld_wd, cap_rd, adv_addr, set_status, to_inc;
    logic last_beat, to_hit;

    // The two address bits below word alignment and the upper HRESP bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{HRESP_M0[1], CMD_ADDR[1:0]};

    assign last_beat = (beats_q == 5'd1);
    // to_hit is true when this stalled cycle would be the TIMEOUT_CYC-th low cycle.
    assign to_hit    = (to_cnt == TW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and datapath load strobes
    always_comb begin
        state_nx   = state;
        ld_cmd     = 1'b0;
        ld_wd      = 1'b0;
        cap_rd     = 1'b0;
        adv_addr   = 1'b0;
        set_status = 1'b0;
        status_nx  = 2'b00;
        to_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    ld_cmd   = 1'b1;
                    state_nx = CMD_WRITE ? S_WFETCH : S_ADDR;
                end
            end
            S_WFETCH: begin
                if (WD_VALID) begin
                    ld_wd    = 1'b1;
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY_M0) begin
                    state_nx = S_DATA;
                end else if (to_hit) begin
                    set_status = 1'b1;
                    status_nx  = 2'b10;
                    state_nx   = S_FINISH;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (HREADY_M0) begin
                    if (HRESP_M0[0]) begin
                        set_status = 1'b1;
                        status_nx  = 2'b01;
                        state_nx   = S_FINISH;
                    end else if (!write_q) begin
                        cap_rd   = 1'b1;
                        state_nx = S_RHOLD;
                    end else if (last_beat) begin
                        set_status = 1'b1;
                        state_nx   = S_FINISH;
                    end else begin
                        adv_addr = 1'b1;
                        state_nx = S_WFETCH;
                    end
                end else if (to_hit) begin
                    set_status = 1'b1;
                    status_nx  = 2'b10;
                    state_nx   = S_FINISH;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_RHOLD: begin
                if (RD_READY) begin
                    if (last_beat) begin
                        set_status = 1'b1;
                        state_nx   = S_FINISH;
                    end else begin
                        adv_addr = 1'b1;
                        state_nx = S_ADDR;
                    end
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Command, data and timeout registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            beats_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            status_q <= 2'b00;
            to_cnt   <= '0;
        end else begin
            if (ld_cmd) begin
                addr_q  <= {CMD_ADDR[31:2], 2'b00};
                write_q <= CMD_WRITE;
                beats_q <= {1'b0, CMD_LEN} + 5'd1;
            end
            if (ld_wd)
                wdata_q <= WD_DATA;
            if (adv_addr) begin
                addr_q  <= addr_q + 32'(ADDR_INC);
                beats_q <= beats_q - 5'd1;
            end
            if (cap_rd) begin
                rdata_q <= HRDATA_M0;
                rlast_q <= last_beat;
            end
            if (set_status)
                status_q <= status_nx;
            // The stall budget is per transfer, so it restarts on every entry to the address phase.
            if (state_nx == S_ADDR && state != S_ADDR)
                to_cnt <= '0;
            else if (to_inc)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign CMD_READY    = (state == S_IDLE);
    assign WD_READY     = (state == S_WFETCH);
    assign RD_VALID     = (state == S_RHOLD);
    assign DONE         = (state == S_FINISH);
    assign RD_DATA      = rdata_q;
    assign RD_LAST      = rlast_q;
    assign STATUS       = status_q;
    assign HTRANS_M0    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign HADDR_M0     = addr_q;
    assign HWRITE_M0    = write_q;
    assign HWDATA_M0    = wdata_q;
    assign HSIZE_M0     = 3'b010;
    assign HBURST_M0    = 3'b000;
    assign HPROT_M0     = 4'b0011;
    assign HMASTLOCK_M0 = 1'b0;

endmodule

// File: tb/tb_ahb_boot_master.sv
// Bench for ahb_boot_master. It contains a zero/random-wait AHB slave with
// error and stall injection and a burst-level reference model. It runs a
// table of directed commands, hand-written corner sequences and random commands.
module tb_ahb_boot_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [3:0]  CMD_LEN;
    logic        WD_VALID, WD_READY;
    logic [31:0] WD_DATA;
    logic        RD_VALID, RD_READY, RD_LAST, DONE;
    logic [31:0] RD_DATA;
    logic [1:0]  STATUS;
    logic [31:0] HADDR_M0, HWDATA_M0;
    logic [31:0] HRDATA_M0 = '0;
    logic [1:0]  HTRANS_M0;
    logic        HWRITE_M0, HMASTLOCK_M0;
    logic [2:0]  HSIZE_M0, HBURST_M0;
    logic [3:0]  HPROT_M0;
    logic        HREADY_M0 = 1'b1;
    logic [1:0]  HRESP_M0 = 2'b00;

    always #5 HCLK = ~HCLK;

    ahb_boot_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
        .CMD_WRITE(CMD_WRITE), .CMD_LEN(CMD_LEN),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .DONE(DONE), .STATUS(STATUS),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0),
        .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
        .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Slave memory (changed by observed bus writes) and reference memory (changed by the model).
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] initv(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction
    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : initv(a);
    endfunction
    function automatic logic [31:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : initv(a);
    endfunction

    // Slave controls: random wait rate, and the global transfer index that gets ERROR or a permanent stall.
    int wait_pct = 0;
    int err_at   = -1;
    int to_at    = -1;

    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    bit          pend_wr = 1'b0;
    int          pend_idx = 0;
    int          n_ns = 0, n_done = 0, viol = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_wd[$];
    bit          obs_awr[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    // Slave response for the coming cycle
    always @(posedge HCLK) begin
        #1;
        if (pend && pend_idx == to_at) HREADY_M0 = 1'b0;
        else                           HREADY_M0 = ($urandom_range(99) >= wait_pct);
        HRESP_M0  = (pend && HREADY_M0 && pend_idx == err_at) ? 2'b01 : 2'b00;
        HRDATA_M0 = pend ? sget(pend_addr) : $urandom;
    end

    // Bus monitor at mid-cycle: bookkeeping of transfers plus protocol invariants
    always @(negedge HCLK) begin
        if (HRESET) begin
            pend       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (HTRANS_M0 != 2'b10 || HADDR_M0 != prev_addr)) viol++;
            if (HTRANS_M0 == 2'b10 && (RD_VALID || WD_READY || DONE)) viol++;
            if (HTRANS_M0 != 2'b00 && HTRANS_M0 != 2'b10) viol++;
            if (HSIZE_M0 != 3'b010 || HBURST_M0 != 3'b000 || HPROT_M0 != 4'b0011 || HMASTLOCK_M0) viol++;
            if (pend && HREADY_M0) begin
                if (pend_wr && !HRESP_M0[0]) begin
                    smem[pend_addr] = HWDATA_M0;
                    obs_wd.push_back(HWDATA_M0);
                end
                pend = 1'b0;
            end
            if (DONE) begin
                pend = 1'b0;
                n_done++;
            end
            if (HTRANS_M0 == 2'b10 && HREADY_M0) begin
                obs_addr.push_back(HADDR_M0);
                obs_awr.push_back(HWRITE_M0);
                pend      = 1'b1;
                pend_addr = HADDR_M0;
                pend_wr   = HWRITE_M0;
                pend_idx  = n_ns;
                n_ns++;
            end
            prev_stall = (HTRANS_M0 == 2'b10) && !HREADY_M0;
            prev_addr  = HADDR_M0;
        end
    end

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        int          len;
        int          err_beat;    // beat answered with ERROR, -1 none
        int          to_beat;     // beat whose data phase never completes, -1 none
        int          wpct;        // slave wait-state percentage
        int          vpct;        // WD_VALID / RD_READY percentage
        int          gap_beat;    // write beat preceded by 5 WD_VALID-low fetch cycles
        int          rd_hold;     // read beat held with RD_READY low for 3 cycles
        int          exp_status;  // -1: take from model
        int          exp_ns;      // -1: take from model
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input bit w, input int l, input int e, input int t,
                                input int wp, input int vp, input int g, input int rh, input int st, input int ns);
        vec_t v;
        v.addr = a; v.wr = w; v.len = l; v.err_beat = e; v.to_beat = t; v.wpct = wp; v.vpct = vp;
        v.gap_beat = g; v.rd_hold = rh; v.exp_status = st; v.exp_ns = ns;
        return v;
    endfunction

    task automatic do_reset();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    // Run one command, predicting its bus transfers, data words and status from burst arithmetic.
    task automatic run_cmd(input vec_t v, input string nm);
        int nb, stop, e_stat, e_ns, a0, w0, d0, bns;
        int k, r, wdw, rdw, cyc;
        bit accepted, done;
        logic [1:0]  got;
        logic [31:0] base, a;
        logic [31:0] wd[$], e_addr[$], e_wd[$], e_rd[$], o_rd[$];
        bit          e_last[$], o_last[$];

        nb     = v.len + 1;
        base   = {v.addr[31:2], 2'b00};
        stop   = nb;
        e_stat = 0;
        if (v.err_beat >= 0 && v.err_beat < nb) begin stop = v.err_beat; e_stat = 1; end
        else if (v.to_beat >= 0 && v.to_beat < nb) begin stop = v.to_beat; e_stat = 2; end
        e_ns = (stop < nb) ? stop + 1 : nb;
        for (int i = 0; i < nb; i++) wd.push_back($urandom);
        for (int i = 0; i < e_ns; i++) begin
            a = base + 32'(i * 4);
            e_addr.push_back(a);
            if (i < stop) begin
                if (v.wr) begin
                    rmem[a] = wd[i];
                    e_wd.push_back(wd[i]);
                end else begin
                    e_rd.push_back(rget(a));
                    e_last.push_back(i == nb - 1);
                end
            end
        end
        if (v.exp_status >= 0) e_stat = v.exp_status;
        if (v.exp_ns >= 0)     e_ns   = v.exp_ns;

        @(posedge HCLK);
        a0 = obs_addr.size(); w0 = obs_wd.size(); d0 = n_done; bns = n_ns;
        err_at   = (v.err_beat >= 0) ? bns + v.err_beat : -1;
        to_at    = (v.to_beat >= 0) ? bns + v.to_beat : -1;
        wait_pct = v.wpct;
        CMD_ADDR = v.addr; CMD_WRITE = v.wr; CMD_LEN = 4'(v.len);
        accepted = 0; done = 0; k = 0; r = 0; wdw = 0; rdw = 0; cyc = 0; got = 2'b11;
        while (!done && cyc < 4000) begin
            #1;
            CMD_VALID = !accepted;
            WD_VALID  = v.wr && k < nb && !(k == v.gap_beat && wdw < 5) && ($urandom_range(99) < v.vpct);
            WD_DATA   = (k < nb) ? wd[k] : 32'h0;
            RD_READY  = !v.wr && !(r == v.rd_hold && rdw < 3) && ($urandom_range(99) < v.vpct);
            @(negedge HCLK);
            if (CMD_VALID && CMD_READY) accepted = 1;
            if (WD_VALID && WD_READY) begin k++; wdw = 0; end
            else if (WD_READY) wdw++;
            if (RD_VALID && RD_READY) begin
                o_rd.push_back(RD_DATA); o_last.push_back(RD_LAST); r++; rdw = 0;
            end else if (RD_VALID) rdw++;
            if (DONE) begin done = 1; got = STATUS; end
            @(posedge HCLK);
            cyc++;
        end
        #1;
        CMD_VALID = 0; WD_VALID = 0; RD_READY = 0;
        chk({nm, " done seen"}, 32'(done), 32'd1);
        if (!done) do_reset();
        chk({nm, " status"}, 32'(got), 32'(e_stat));
        chk({nm, " status held"}, 32'(STATUS), 32'(e_stat));
        chk({nm, " done pulses"}, 32'(n_done - d0), 32'd1);
        chk({nm, " nonseq count"}, 32'(obs_addr.size() - a0), 32'(e_ns));
        for (int i = 0; i < e_ns && a0 + i < obs_addr.size(); i++) begin
            chk($sformatf("%s haddr[%0d]", nm, i), obs_addr[a0 + i], e_addr[i]);
            chk($sformatf("%s hwrite[%0d]", nm, i), 32'(obs_awr[a0 + i]), 32'(v.wr));
        end
        if (v.wr) begin
            chk({nm, " wd consumed"}, 32'(k), 32'(e_ns));
            chk({nm, " write count"}, 32'(obs_wd.size() - w0), 32'(e_wd.size()));
            for (int i = 0; i < e_wd.size() && w0 + i < obs_wd.size(); i++)
                chk($sformatf("%s hwdata[%0d]", nm, i), obs_wd[w0 + i], e_wd[i]);
        end else begin
            chk({nm, " read count"}, 32'(o_rd.size()), 32'(e_rd.size()));
            for (int i = 0; i < e_rd.size() && i < o_rd.size(); i++) begin
                chk($sformatf("%s rd_data[%0d]", nm, i), o_rd[i], e_rd[i]);
                chk($sformatf("%s rd_last[%0d]", nm, i), 32'(o_last[i]), 32'(e_last[i]));
            end
        end
        err_at = -1; to_at = -1;
    endtask

    vec_t tbl[14];

    initial begin
        vec_t rv;
        int   l, hit, d0, b;

        tbl[0]  = mk(32'h0000_0103, 1, 0,  -1, -1, 0,  100, -1, -1, 0, 1);
        tbl[1]  = mk(32'h0000_0100, 0, 0,  -1, -1, 0,  100, -1, -1, 0, 1);
        tbl[2]  = mk(32'h0000_0200, 0, 3,  -1, -1, 0,  100, -1,  1, 0, 4);
        tbl[3]  = mk(32'h0000_0300, 1, 2,  -1, -1, 0,  100,  1, -1, 0, 3);
        tbl[4]  = mk(32'h0000_0300, 0, 2,  -1, -1, 20, 70,  -1, -1, 0, 3);
        tbl[5]  = mk(32'h0000_0200, 0, 2,   1, -1, 0,  100, -1, -1, 1, 2);
        tbl[6]  = mk(32'h0000_0204, 0, 0,  -1,  0, 0,  100, -1, -1, 2, 1);
        tbl[7]  = mk(32'h0000_0400, 1, 1,  -1, -1, 0,  100, -1, -1, 0, 2);
        tbl[8]  = mk(32'hFFFF_FFFC, 1, 1,  -1, -1, 10, 80,  -1, -1, 0, 2);
        tbl[9]  = mk(32'hFFFF_FFFE, 0, 1,  -1, -1, 10, 80,  -1, -1, 0, 2);
        tbl[10] = mk(32'h0000_1000, 1, 15, -1, -1, 30, 60,  -1, -1, 0, 16);
        tbl[11] = mk(32'h0000_0600, 1, 1,   0, -1, 0,  100, -1, -1, 1, 1);
        tbl[12] = mk(32'h0000_0500, 1, 2,  -1,  1, 0,  100, -1, -1, 2, 2);
        tbl[13] = mk(32'h0000_1000, 0, 15, -1, -1, 30, 60,  -1, -1, 0, 16);

        HRESET = 1'b1; CMD_VALID = 0; CMD_ADDR = '0; CMD_WRITE = 0; CMD_LEN = '0;
        WD_VALID = 0; WD_DATA = '0; RD_READY = 0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst CMD_READY", 32'(CMD_READY), 32'd1);
        chk("rst WD_READY",  32'(WD_READY),  32'd0);
        chk("rst RD_VALID",  32'(RD_VALID),  32'd0);
        chk("rst RD_LAST",   32'(RD_LAST),   32'd0);
        chk("rst DONE",      32'(DONE),      32'd0);
        chk("rst STATUS",    32'(STATUS),    32'd0);
        chk("rst HTRANS",    32'(HTRANS_M0), 32'd0);
        chk("rst HADDR",     HADDR_M0,       32'd0);
        chk("rst HWRITE",    32'(HWRITE_M0), 32'd0);
        chk("rst HWDATA",    HWDATA_M0,      32'd0);
        chk("const HSIZE",   32'(HSIZE_M0),  32'd2);
        chk("const HPROT",   32'(HPROT_M0),  32'd3);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Single write with zero waits: cycle-exact timing from acceptance to DONE
        @(posedge HCLK); #1;
        wait_pct = 0;
        CMD_VALID = 1; CMD_ADDR = 32'h0000_0103; CMD_WRITE = 1; CMD_LEN = 4'd0;
        WD_VALID = 1; WD_DATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        chk("sw c0 CMD_READY", 32'(CMD_READY), 32'd1);
        @(posedge HCLK); #1; CMD_VALID = 0;
        @(negedge HCLK);
        chk("sw c1 WD_READY", 32'(WD_READY), 32'd1);
        chk("sw c1 HTRANS", 32'(HTRANS_M0), 32'd0);
        @(posedge HCLK); #1; WD_VALID = 0;
        @(negedge HCLK);
        chk("sw c2 HTRANS", 32'(HTRANS_M0), 32'd2);
        chk("sw c2 HADDR", HADDR_M0, 32'h0000_0100);
        chk("sw c2 HWRITE", 32'(HWRITE_M0), 32'd1);
        @(negedge HCLK);
        chk("sw c3 HTRANS", 32'(HTRANS_M0), 32'd0);
        chk("sw c3 HWDATA", HWDATA_M0, 32'hDEAD_BEEF);
        chk("sw c3 DONE", 32'(DONE), 32'd0);
        @(negedge HCLK);
        chk("sw c4 DONE", 32'(DONE), 32'd1);
        chk("sw c4 STATUS", 32'(STATUS), 32'd0);
        @(negedge HCLK);
        chk("sw c5 DONE", 32'(DONE), 32'd0);
        chk("sw c5 CMD_READY", 32'(CMD_READY), 32'd1);
        rmem[32'h0000_0100] = 32'hDEAD_BEEF;

        for (int i = 0; i < 14; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset during beat 3 of a 16-beat write: bus idles next cycle, no DONE
        b = n_ns; hit = 0;
        @(posedge HCLK); #1;
        wait_pct = 0;
        CMD_VALID = 1; CMD_ADDR = 32'h0000_2000; CMD_WRITE = 1; CMD_LEN = 4'd15;
        WD_VALID = 1; WD_DATA = 32'h1234_0000;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            @(posedge HCLK); #1;
            CMD_VALID = 0; WD_DATA = WD_DATA + 1;
            if (n_ns - b >= 3) hit = 1;
        end
        chk("rstmid beat3 reached", 32'(hit), 32'd1);
        d0 = n_done;
        HRESET = 1;
        @(posedge HCLK); #1;
        chk("rstmid HTRANS", 32'(HTRANS_M0), 32'd0);
        chk("rstmid CMD_READY", 32'(CMD_READY), 32'd1);
        chk("rstmid DONE", 32'(DONE), 32'd0);
        HRESET = 0; WD_VALID = 0;
        repeat (6) @(posedge HCLK);
        #1;
        chk("rstmid no done", 32'(n_done - d0), 32'd0);
        run_cmd(mk(32'h0000_0700, 1, 3, -1, -1, 0, 100, -1, -1, 0, 4), "after rst");

        // Random commands over a small window so reads revisit earlier writes
        for (int n = 0; n < 30; n++) begin
            l  = int'($urandom_range(15));
            rv = mk(32'h0000_0800 + 32'($urandom_range(63)) * 4 + 32'($urandom_range(3)),
                    bit'($urandom_range(1)), l,
                    ($urandom_range(9) == 0) ? int'($urandom_range(l)) : -1, -1,
                    int'($urandom_range(40)), int'($urandom_range(100, 40)), -1, -1, -1, -1);
            run_cmd(rv, $sformatf("rnd%0d", n));
        end

        chk("bus invariants", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_boot_master.md
Name: ahb_boot_master

Overview:
- Command-driven AHB-Lite master that drives the M0 port of the code-memory subsystem (AHB matrix plus LSRAM code store).
- Takes word-burst commands from the UART command decoder and issues them as sequences of single 32-bit AHB transfers.
- Write data arrives on a stream; read data is returned on a stream; one completion status is returned per command.
- The bootloader uses it to load, verify and read back program images.

Parameters:
TIMEOUT_CYC, 256, consecutive HREADY_M0-low cycles in one transfer before the command is aborted; must be >= 2.
ADDR_INC, 4, byte increment between beats.

Ports:
HCLK  input  1  system clock; all logic is on the rising edge.
HRESET  input  1  reset.
CMD_VALID  input  1  command valid.
CMD_READY  output  1  block is idle and accepts a command.
CMD_ADDR  input  32  start byte address; bits [1:0] are ignored and forced to 00.
CMD_WRITE  input  1  1 = write command, 0 = read command.
CMD_LEN  input  4  number of beats minus 1 (1 to 16 beats).
WD_VALID  input  1  write data valid.
WD_READY  output  1  write data accepted.
WD_DATA  input  32  write data word.
RD_VALID  output  1  read data valid.
RD_READY  input  1  read data consumer ready.
RD_DATA  output  32  read data word.
RD_LAST  output  1  marks the final beat of a read command.
DONE  output  1  one-cycle pulse when a command completes or aborts.
STATUS  output  2  00 OK, 01 HRESP error, 10 timeout; valid while DONE = 1 and held until the next DONE.
HADDR_M0  output  32  AHB address.
HTRANS_M0  output  2  AHB transfer type: 00 IDLE or 10 NONSEQ only.
HWRITE_M0  output  1  AHB write.
HSIZE_M0  output  3  constant 010 (word).
HBURST_M0  output  3  constant 000 (SINGLE).
HPROT_M0  output  4  constant 0011.
HMASTLOCK_M0  output  1  constant 0.
HWDATA_M0  output  32  AHB write data.
HRDATA_M0  input  32  AHB read data.
HREADY_M0  input  1  AHB ready.
HRESP_M0  input  2  AHB response; bit 0 set = ERROR.

Behaviour:
- Clocking and reset: one clock, HCLK; reset HRESET is synchronous and active-high.
- Reset values:
  - CMD_READY = 1.
  - WD_READY, RD_VALID, RD_LAST, DONE = 0.
  - STATUS = 00.
  - HTRANS_M0 = 00, HADDR_M0 = 0, HWRITE_M0 = 0, HWDATA_M0 = 0.
  - State = IDLE; beat and timeout counters = 0.
- Reset mid-command: HTRANS_M0 returns to IDLE in the following cycle, the command is dropped, and DONE is not pulsed.
- States: IDLE, WFETCH, ADDR, DATA, RHOLD, FINISH.
- IDLE:
  - CMD_READY = 1.
  - On CMD_VALID, latch address (with [1:0] = 00), direction and beats remaining = CMD_LEN + 1.
  - Go to WFETCH for a write, ADDR for a read.
- WFETCH:
  - WD_READY = 1.
  - On WD_VALID, latch WD_DATA into the write-data register and go to ADDR.
  - Any number of stall cycles is allowed; no AHB activity occurs during the stall.
- ADDR:
  - Drive HTRANS_M0 = 10, HADDR_M0 = current address, HWRITE_M0 = direction.
  - The address phase is held stable until a cycle with HREADY_M0 = 1, then go to DATA.
- DATA:
  - HTRANS_M0 = 00; HWDATA_M0 = latched word for writes.
  - Wait for HREADY_M0 = 1, then:
    - HRESP_M0[0] = 1: STATUS = 01, go to FINISH, and drop the remaining beats.
    - Read: capture HRDATA_M0 into RD_DATA, set RD_LAST when this is the last beat, go to RHOLD.
    - Write, more beats remaining: address += ADDR_INC (wraps modulo 2^32), go to WFETCH.
    - Write, last beat: STATUS = 00, go to FINISH.
- RHOLD:
  - RD_VALID = 1; RD_DATA and RD_LAST are stable until RD_READY.
  - On the handshake: if more beats remain, increment the address and go to ADDR; otherwise STATUS = 00 and go to FINISH.
  - No AHB transfer is issued while read data is unconsumed.
- Timeout:
  - The counter increments on each ADDR or DATA cycle with HREADY_M0 = 0 and clears on entry to ADDR.
  - On reaching TIMEOUT_CYC: STATUS = 10, HTRANS_M0 = 00, go to FINISH.
- FINISH: DONE = 1 for one cycle, then go to IDLE. CMD_READY rises the cycle after DONE.
- Latency for a single write with zero wait states and WD_VALID already high:
  - Command accepted in cycle 0.
  - WFETCH in cycle 1, ADDR in cycle 2, DATA in cycle 3.
  - DONE in cycle 4.
- Beat period with zero wait states: 3 cycles per write beat, and 3 cycles per read beat when RD_READY is held high.

Test Plan:
- Single write: CMD addr=0x00000103, LEN=0, WRITE=1, WD=0xDEADBEEF, zero-wait memory -> NONSEQ at HADDR 0x00000100, HWDATA 0xDEADBEEF in the next cycle, DONE with STATUS=00 four cycles after command acceptance.
- Four-beat read from 0x00000200, RD_READY low for 3 cycles on beat 2 -> addresses 0x200/0x204/0x208/0x20C, no NONSEQ while RD_VALID is pending, RD_LAST only on beat 4, STATUS=00.
- Write of 3 beats with WD_VALID gapped by 5 cycles before beat 2 -> HTRANS stays IDLE during the gap, data order preserved, DONE after beat 3.
- HRESP=ERROR on beat 2 of a 3-beat read -> one RD_VALID beat only, no third NONSEQ, DONE with STATUS=01.
- HREADY_M0 held low for 256 cycles in the data phase -> DONE with STATUS=10 and HTRANS=IDLE; a follow-up command executes normally.
- HRESET asserted during beat 3 of a 16-beat write -> next cycle HTRANS=00, CMD_READY=1, no DONE; address wrap check: start 0xFFFFFFFC, LEN=1 gives a second beat at 0x00000000.
